// File: rtl/mcu0_pkg.sv
// Shared definitions for the mcu0 interrupt controller: FSM encoding,
// register addresses and STATUS bit positions.
package mcu0_pkg;

  typedef enum logic [1:0] {
    INTC_IDLE    = 2'd0,
    INTC_REQ     = 2'd1,
    INTC_SERVICE = 2'd2
  } intc_state_e;

  localparam logic [1:0] INTC_MASK = 2'd0;
  localparam logic [1:0] INTC_EDGE = 2'd1;
  localparam logic [1:0] INTC_PEND = 2'd2;
  localparam logic [1:0] INTC_STAT = 2'd3;

  localparam int STAT_STATE_MSB = 15;
  localparam int STAT_STATE_LSB = 14;
  localparam int STAT_ERR_BIT   = 13;

endpackage

// File: rtl/mcu0_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module mcu0_prio_enc
  import mcu0_pkg::*;
#(
  parameter int NIRQ  = 8,
  parameter int VEC_W = 3
) (
  input  logic [NIRQ-1:0]  i_req,
  output logic             o_valid,
  output logic [VEC_W-1:0] o_vec
);

  always_comb begin
    o_valid = 1'b0;
    o_vec   = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_vec   = VEC_W'(i);
      end
    end
  end

endmodule

// File: rtl/mcu0_intc.sv
// Interrupt controller for the mcu0 core: synchronizes request lines, keeps
// per-source mask/mode/pending state and presents one vector at a time.
//
// state   | meaning
// IDLE    | nothing presented; arbitrate among eligible sources
// REQ     | interrupt asserted with a stable vector; waiting for int_ack
// SERVICE | core is in the handler; waiting for iret
module mcu0_intc
  import mcu0_pkg::*;
#(
  parameter int NIRQ  = 8,
  parameter int VEC_W = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [NIRQ-1:0]  irq_src,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [15:0]      cfg_wdata,
  output logic [15:0]      cfg_rdata,
  output logic             interrupt,
  output logic [VEC_W-1:0] irq,
  input  logic             int_ack,
  input  logic             iret
);

  logic [NIRQ-1:0]  r_sync1, r_sync2, r_sync3, r_rise;
  logic [NIRQ-1:0]  r_mask, r_edge, r_pend;
  intc_state_e      r_state;
  logic             r_err, r_int;
  logic [VEC_W-1:0] r_irq;

  logic [NIRQ-1:0]  w_elig, w_clr, w_ack_bit, w_pend_nxt;
  logic             w_valid, w_ack_ok, w_misuse;
  logic             w_wr_mask, w_wr_edge, w_wr_pend, w_wr_stat;
  logic [VEC_W-1:0] w_vec;
  logic [15:0]      w_stat;
  logic             w_unused;

  assign w_unused  = ^cfg_wdata;
  assign w_elig    = r_pend & r_mask;
  assign w_wr_mask = cfg_we && (cfg_addr == INTC_MASK);
  assign w_wr_edge = cfg_we && (cfg_addr == INTC_EDGE);
  assign w_wr_pend = cfg_we && (cfg_addr == INTC_PEND);
  assign w_wr_stat = cfg_we && (cfg_addr == INTC_STAT);
  assign w_ack_ok  = int_ack && (r_state == INTC_REQ);
  assign w_misuse  = (int_ack && (r_state != INTC_REQ)) ||
                     (iret && (r_state != INTC_SERVICE));
  assign w_ack_bit = NIRQ'(1) << r_irq;
  assign w_clr     = ({NIRQ{w_wr_pend}} & cfg_wdata[NIRQ-1:0]) |
                     ({NIRQ{w_ack_ok}} & w_ack_bit);
  // Edge bits: a fresh rise beats any clear in the same cycle.
  assign w_pend_nxt = (r_edge & ((r_pend & ~w_clr) | r_rise)) |
                      (~r_edge & r_sync2);

  assign interrupt = r_int;
  assign irq       = r_irq;

  mcu0_prio_enc #(.NIRQ(NIRQ), .VEC_W(VEC_W)) u_prio (
    .i_req   (w_elig),
    .o_valid (w_valid),
    .o_vec   (w_vec)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
      r_rise  <= '0;
      r_mask  <= '0;
      r_edge  <= '0;
      r_pend  <= '0;
    end else begin
      r_sync1 <= irq_src;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_rise  <= r_sync2 & ~r_sync3;
      r_pend  <= w_pend_nxt;
      if (w_wr_mask) r_mask <= cfg_wdata[NIRQ-1:0];
      if (w_wr_edge) r_edge <= cfg_wdata[NIRQ-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= INTC_IDLE;
      r_int   <= 1'b0;
      r_irq   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_misuse)       r_err <= 1'b1;
      else if (w_wr_stat) r_err <= 1'b0;
      case (r_state)
        INTC_IDLE: begin
          if (w_valid) begin
            r_irq   <= w_vec;
            r_int   <= 1'b1;
            r_state <= INTC_REQ;
          end
        end
        INTC_REQ: begin
          if (int_ack) begin
            r_int   <= 1'b0;
            r_state <= INTC_SERVICE;
          end else if (!w_elig[r_irq]) begin
            r_int   <= 1'b0;
            r_state <= INTC_IDLE;
          end
        end
        INTC_SERVICE: begin
          if (iret) r_state <= INTC_IDLE;
        end
        default: begin
          r_int   <= 1'b0;
          r_state <= INTC_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_stat = '0;
    w_stat[STAT_STATE_MSB:STAT_STATE_LSB] = r_state;
    w_stat[STAT_ERR_BIT] = r_err;
    w_stat[VEC_W-1:0]    = r_irq;
    cfg_rdata = '0;
    case (cfg_addr)
      INTC_MASK: cfg_rdata = 16'(r_mask);
      INTC_EDGE: cfg_rdata = 16'(r_edge);
      INTC_PEND: cfg_rdata = 16'(r_pend);
      INTC_STAT: cfg_rdata = w_stat;
      default:   cfg_rdata = '0;
    endcase
  end

endmodule
